// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit: the per-stage
// prediction record and the sequential next-PC function.
package bru_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] npc_pred;
  } pred_slot_t;

  function automatic logic [31:0] next_seq(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/bru_slot_reg.sv
// One pipeline slot holding a prediction record; clear beats hold beats load.
module bru_slot_reg
  import bru_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  pred_slot_t slot_in,
  output pred_slot_t slot_out
);

  pred_slot_t slot_q, slot_d;

  // A cleared slot only drops valid; the stale payload is never consumed.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d.valid = 1'b0;
    end else if (!hold) begin
      slot_d = slot_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_out = slot_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch predictions to E, resolves them against the real branch
// outcome, raises a redirect on mispredictions and counts branches/misses.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  input  logic             PredF,
  input  logic [31:0]      NPC_PredF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             IsBranchE,
  input  logic             BrTakenE,
  input  logic [31:0]      BrNPC,
  output logic [31:0]      PCE,
  output logic             PredE,
  output logic [31:0]      NPC_PredE,
  output logic             BranchE,
  output logic             RedirectE,
  output logic [31:0]      RedirectPC,
  output logic [CNT_W-1:0] BrCnt,
  output logic [CNT_W-1:0] MissCnt
);

  pred_slot_t f_slot, d_slot, e_slot;
  logic        res;
  logic        pred_e;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  assign f_slot = '{valid: 1'b1, pc: PCF, pred: PredF, npc_pred: NPC_PredF};

  bru_slot_reg u_slot_d (
    .clk      (clk),
    .rst      (rst),
    .clr      (FlushD | redirect),
    .hold     (StallD),
    .slot_in  (f_slot),
    .slot_out (d_slot)
  );

  bru_slot_reg u_slot_e (
    .clk      (clk),
    .rst      (rst),
    .clr      (FlushE | redirect),
    .hold     (StallE),
    .slot_in  (d_slot),
    .slot_out (e_slot)
  );

  // Target is only compared for taken branches; a prediction on anything
  // that falls through (not-taken or non-branch) is wrong by definition.
  always_comb begin
    pred_e      = e_slot.valid & e_slot.pred;
    res         = e_slot.valid & ~StallE;
    redirect    = 1'b0;
    redirect_pc = next_seq(e_slot.pc);
    if (res) begin
      if (IsBranchE && BrTakenE) begin
        if (!pred_e || (e_slot.npc_pred != BrNPC)) begin
          redirect    = 1'b1;
          redirect_pc = BrNPC;
        end
      end else if (pred_e) begin
        redirect = 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (res && IsBranchE && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (redirect && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign PCE        = e_slot.pc;
  assign PredE      = pred_e;
  assign NPC_PredE  = e_slot.npc_pred;
  assign BranchE    = e_slot.valid & IsBranchE & BrTakenE;
  assign RedirectE  = redirect;
  assign RedirectPC = redirect_pc;
  assign BrCnt      = br_cnt_q;
  assign MissCnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a
// cycle-level reference model of the prediction pipe and resolution rules.
module tb_branch_resolve_unit;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   PCF, NPC_PredF, BrNPC;
  logic          PredF, StallD, FlushD, StallE, FlushE, IsBranchE, BrTakenE;
  logic [31:0]   PCE, NPC_PredE, RedirectPC;
  logic          PredE, BranchE, RedirectE;
  logic [CW-1:0] BrCnt, MissCnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          p;
    logic [31:0] n;
  } rec_t;

  rec_t m_d, m_e;
  int   m_br, m_miss;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredF(PredF), .NPC_PredF(NPC_PredF),
    .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
    .IsBranchE(IsBranchE), .BrTakenE(BrTakenE), .BrNPC(BrNPC),
    .PCE(PCE), .PredE(PredE), .NPC_PredE(NPC_PredE), .BranchE(BranchE),
    .RedirectE(RedirectE), .RedirectPC(RedirectPC), .BrCnt(BrCnt), .MissCnt(MissCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_d    = '{v: 0, pc: 0, p: 0, n: 0};
    m_e    = '{v: 0, pc: 0, p: 0, n: 0};
    m_br   = 0;
    m_miss = 0;
  endtask

  // What should happen to the instruction in E, from the resolution table.
  task automatic model_resolve(output bit redir, output logic [31:0] tgt);
    bit pred_e, taken;
    pred_e = m_e.v && m_e.p;
    taken  = IsBranchE && BrTakenE;
    redir  = 0;
    tgt    = m_e.pc + 32'd4;
    if (m_e.v && !StallE) begin
      if (taken && (!pred_e || m_e.n != BrNPC)) begin
        redir = 1;
        tgt   = BrNPC;
      end else if (!taken && pred_e) begin
        redir = 1;
      end
    end
  endtask

  // Inputs are set by the caller just after a negedge; check then clock.
  task automatic cycle();
    bit          redir;
    logic [31:0] tgt;
    rec_t        f_rec;
    #1;
    model_resolve(redir, tgt);
    chk("PredE", 32'(PredE), 32'(m_e.v && m_e.p));
    chk("BranchE", 32'(BranchE), 32'(m_e.v && IsBranchE && BrTakenE));
    chk("RedirectE", 32'(RedirectE), 32'(redir));
    if (redir) chk("RedirectPC", RedirectPC, tgt);
    if (m_e.v) begin
      chk("PCE", PCE, m_e.pc);
      chk("NPC_PredE", NPC_PredE, m_e.n);
    end
    chk("BrCnt", 32'(BrCnt), 32'(m_br));
    chk("MissCnt", 32'(MissCnt), 32'(m_miss));
    $display("cyc %0d pce=%h vE=%0d predE=%0d br=%0d tk=%0d redir=%0d rpc=%h brcnt=%0d miss=%0d",
             cyc, PCE, m_e.v, PredE, IsBranchE, BrTakenE, RedirectE, RedirectPC, BrCnt, MissCnt);
    @(posedge clk);
    f_rec = '{v: 1, pc: PCF, p: PredF, n: NPC_PredF};
    if (m_e.v && !StallE && IsBranchE && m_br < CNT_MAX) m_br++;
    if (redir && m_miss < CNT_MAX) m_miss++;
    if (FlushE || redir) m_e.v = 0;
    else if (!StallE) m_e = m_d;
    if (FlushD || redir) m_d.v = 0;
    else if (!StallD) m_d = f_rec;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    PCF = 32'h1000 + 32'(cyc * 4); PredF = 0; NPC_PredF = 0;
    StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
    IsBranchE = 0; BrTakenE = 0; BrNPC = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_PCE", PCE, 32'h0);
    chk("rst_PredE", 32'(PredE), 32'h0);
    chk("rst_NPC", NPC_PredE, 32'h0);
    chk("rst_BranchE", 32'(BranchE), 32'h0);
    chk("rst_RedirectE", 32'(RedirectE), 32'h0);
    chk("rst_RedirectPC", RedirectPC, 32'h4);
    chk("rst_BrCnt", 32'(BrCnt), 32'h0);
    chk("rst_MissCnt", 32'(MissCnt), 32'h0);
  endtask

  // Send one record from F and resolve it two cycles later with the given outcome.
  task automatic run_br(input logic [31:0] pc, input bit pred, input logic [31:0] npc,
                        input bit isb, input bit tk, input logic [31:0] brnpc);
    idle(); PCF = pc; PredF = pred; NPC_PredF = npc;
    cycle();
    idle();
    cycle();
    idle(); IsBranchE = isb; BrTakenE = tk; BrNPC = brnpc;
    cycle();
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    #2;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    run_br(32'h40, 1, 32'h80, 1, 1, 32'h80);   // correct taken
    run_br(32'h40, 1, 32'h80, 1, 0, 32'h80);   // not taken, predicted taken
    run_br(32'h40, 1, 32'h80, 1, 1, 32'h100);  // target mismatch
    run_br(32'h40, 0, 32'h80, 1, 1, 32'h100);  // taken, predicted not taken
    run_br(32'hFFFFFFFC, 1, 32'h80, 0, 0, 0);  // aliased entry, PC+4 wraps
    run_br(32'h60, 0, 32'h0, 0, 0, 0);         // plain non-branch

    // Mispredict stuck behind a 3-cycle E stall.
    idle(); PCF = 32'h40; PredF = 1; NPC_PredF = 32'h80; cycle();
    idle(); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); StallE = 1; StallD = 1; IsBranchE = 1; BrTakenE = 0; cycle();
    end
    idle(); IsBranchE = 1; BrTakenE = 0; StallD = 1; cycle();
    idle(); cycle();

    // Predicted record flushed out of E before resolution.
    idle(); PCF = 32'h200; PredF = 1; NPC_PredF = 32'h300; cycle();
    idle(); FlushE = 1; cycle();
    idle(); IsBranchE = 1; BrTakenE = 1; BrNPC = 32'h300; cycle();

    // Randomized traffic; long enough to drive both counters into saturation.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] sel;
      sel       = 32'($urandom_range(0, 7));
      PCF       = (sel == 7) ? 32'hFFFFFFFC : (32'h40 + (sel << 2));
      PredF     = 1'($urandom_range(0, 1));
      NPC_PredF = $urandom_range(0, 1) ? 32'h80 : 32'h100;
      StallD    = ($urandom_range(0, 9) < 2);
      FlushD    = ($urandom_range(0, 9) < 1);
      StallE    = ($urandom_range(0, 9) < 2);
      FlushE    = ($urandom_range(0, 9) < 1);
      IsBranchE = ($urandom_range(0, 9) < 6);
      BrTakenE  = 1'($urandom_range(0, 1));
      BrNPC     = $urandom_range(0, 3) != 0 ? 32'h80 : 32'h100;
      if (i == 250) begin
        // Asynchronous reset in the middle of the stream.
        #3 rst = 1;
        #1 chk_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst = 0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
